// File: rtl/dec_gpr_scoreboard_if.sv
// Decode/scoreboard/GPR-writeback bundle: issue request, load and divide
// returns, and the two registered GPR write ports.
interface dec_gpr_scoreboard_if #(
    parameter int TAG_W = 2
);
    logic             issue_valid;
    logic             issue_rs1_en;
    logic [4:0]       issue_rs1;
    logic             issue_rs2_en;
    logic [4:0]       issue_rs2;
    logic             issue_rd_en;
    logic [4:0]       issue_rd;
    logic             issue_nbload;
    logic             issue_div;
    logic [TAG_W-1:0] issue_tag;
    logic             issue_stall;

    logic             ld_ret_valid;
    logic [TAG_W-1:0] ld_ret_tag;
    logic [31:0]      ld_ret_data;

    logic             div_ret_valid;
    logic [31:0]      div_ret_data;
    logic             div_flush;

    logic             wen1;
    logic [4:0]       waddr1;
    logic [31:0]      wd1;
    logic             wen2;
    logic [4:0]       waddr2;
    logic [31:0]      wd2;

    logic             sb_idle;
    logic             sb_err;

    // Decode/LSU/divider side: drives requests and returns, sees stall and writes
    modport master (
        output issue_valid, issue_rs1_en, issue_rs1, issue_rs2_en, issue_rs2,
               issue_rd_en, issue_rd, issue_nbload, issue_div, issue_tag,
               ld_ret_valid, ld_ret_tag, ld_ret_data,
               div_ret_valid, div_ret_data, div_flush,
        input  issue_stall, wen1, waddr1, wd1, wen2, waddr2, wd2,
               sb_idle, sb_err
    );

    // Scoreboard side
    modport slave (
        input  issue_valid, issue_rs1_en, issue_rs1, issue_rs2_en, issue_rs2,
               issue_rd_en, issue_rd, issue_nbload, issue_div, issue_tag,
               ld_ret_valid, ld_ret_tag, ld_ret_data,
               div_ret_valid, div_ret_data, div_flush,
        output issue_stall, wen1, waddr1, wd1, wen2, waddr2, wd2,
               sb_idle, sb_err
    );
endinterface

// File: rtl/dec_gpr_scoreboard.sv
// GPR scoreboard for non-blocking loads and the single outstanding divide.
// Stalls decode on RAW/WAW hazards and registers returning results onto
// GPR write port 1 (loads) and port 2 (divide).
module dec_gpr_scoreboard #(
    parameter int NTAGS = 4,
    parameter int TAG_W = 2
) (
    input logic                 clk,
    input logic                 rst,
    dec_gpr_scoreboard_if.slave sb
);
    // Bit 0 is held at zero so x0 can be indexed without ever hazarding.
    logic [31:0]      busy;
    logic [31:0]      busy_nxt;
    logic [NTAGS-1:0] tag_vld;
    logic [4:0]       tag_rd [NTAGS];
    logic             div_vld;
    logic [4:0]       div_rd;

    logic             wen1_q;
    logic [4:0]       waddr1_q;
    logic [31:0]      wd1_q;
    logic             wen2_q;
    logic [4:0]       waddr2_q;
    logic [31:0]      wd2_q;
    logic             err_q;

    logic [TAG_W-1:0] iss_tag;
    logic [TAG_W-1:0] ret_tag;
    logic [4:0]       ld_rd;
    logic             stall;
    logic             accept;
    logic             track_rd;
    logic             ld_alloc;
    logic             div_alloc;
    logic             ld_hit;
    logic             ld_err;
    logic             div_hit;
    logic             div_err;

    assign iss_tag   = sb.issue_tag;
    assign ret_tag   = sb.ld_ret_tag;
    assign ld_rd     = tag_rd[ret_tag];

    assign stall     = sb.issue_valid &
                       ((sb.issue_rs1_en & busy[sb.issue_rs1]) |
                        (sb.issue_rs2_en & busy[sb.issue_rs2]) |
                        (sb.issue_rd_en  & busy[sb.issue_rd])  |
                        (sb.issue_nbload & tag_vld[iss_tag])   |
                        (sb.issue_div    & div_vld));
    assign accept    = sb.issue_valid & ~stall;
    assign track_rd  = sb.issue_rd_en & (sb.issue_rd != 5'd0);
    assign ld_alloc  = accept & sb.issue_nbload;
    assign div_alloc = accept & sb.issue_div & track_rd;

    assign ld_hit    = sb.ld_ret_valid & tag_vld[ret_tag];
    assign ld_err    = sb.ld_ret_valid & ~tag_vld[ret_tag];
    // A return racing a flush belongs to the killed divide and is dropped quietly.
    assign div_hit   = sb.div_ret_valid & ~sb.div_flush & div_vld;
    assign div_err   = sb.div_ret_valid & ~sb.div_flush & ~div_vld;

    // Load tag table: free on a valid return, allocate on an accepted nbload
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
            for (int i = 0; i < NTAGS; i++) begin
                tag_rd[i] <= 5'd0;
            end
        end else begin
            if (ld_hit) begin
                tag_vld[ret_tag] <= 1'b0;
            end
            if (ld_alloc) begin
                tag_vld[iss_tag] <= 1'b1;
                tag_rd[iss_tag]  <= sb.issue_rd_en ? sb.issue_rd : 5'd0;
            end
        end
    end

    // Single outstanding divide: allocate on accept, retire on return or flush
    always_ff @(posedge clk) begin
        if (rst) begin
            div_vld <= 1'b0;
            div_rd  <= 5'd0;
        end else if (div_alloc) begin
            div_vld <= 1'b1;
            div_rd  <= sb.issue_rd;
        end else if (div_hit || sb.div_flush) begin
            div_vld <= 1'b0;
        end
    end

    // Busy bits clear on the edge the GPR captures the write, set on new tracked issue
    always_comb begin
        busy_nxt = busy;
        if (wen1_q) begin
            busy_nxt[waddr1_q] = 1'b0;
        end
        if (wen2_q) begin
            busy_nxt[waddr2_q] = 1'b0;
        end
        if (sb.div_flush && div_vld) begin
            busy_nxt[div_rd] = 1'b0;
        end
        if ((ld_alloc && track_rd) || div_alloc) begin
            busy_nxt[sb.issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Busy register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Port 1: one-cycle registration of returning load data; x0 loads never write
    always_ff @(posedge clk) begin
        if (rst) begin
            wen1_q   <= 1'b0;
            waddr1_q <= 5'd0;
            wd1_q    <= 32'd0;
        end else begin
            wen1_q <= ld_hit & (ld_rd != 5'd0);
            if (ld_hit) begin
                waddr1_q <= ld_rd;
                wd1_q    <= sb.ld_ret_data;
            end
        end
    end

    // Port 2: one-cycle registration of the returning divide result
    always_ff @(posedge clk) begin
        if (rst) begin
            wen2_q   <= 1'b0;
            waddr2_q <= 5'd0;
            wd2_q    <= 32'd0;
        end else begin
            wen2_q <= div_hit;
            if (div_hit) begin
                waddr2_q <= div_rd;
                wd2_q    <= sb.div_ret_data;
            end
        end
    end

    // Sticky error for returns that match nothing outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (ld_err || div_err) begin
            err_q <= 1'b1;
        end
    end

    assign sb.issue_stall = stall;
    assign sb.wen1        = wen1_q;
    assign sb.waddr1      = waddr1_q;
    assign sb.wd1         = wd1_q;
    assign sb.wen2        = wen2_q;
    assign sb.waddr2      = waddr2_q;
    assign sb.wd2         = wd2_q;
    assign sb.sb_err      = err_q;
    assign sb.sb_idle     = ~(|busy) & ~(|tag_vld) & ~div_vld;
endmodule
